// File: rtl/soc_mem_pkg.sv
// soc_mem_pkg
// Shared definitions for SoC memory masters and arbiters (instruction/data
// arbiter today, cache and DMA masters later).
//   owner_e        : which port owns the read response returning next cycle
//   RAM_AW_DEFAULT : default RAM word-address width (8MB of 32-bit words)
//   STREAK_W       : width of the starvation streak counter (limit 1..15)
package soc_mem_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D_RD = 2'd2
  } owner_e;

  localparam int RAM_AW_DEFAULT = 21;
  localparam int STREAK_W       = 4;

endpackage

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port synchronous RAM (1-cycle read latency) between the
// CPU instruction-fetch port (i_*) and data port (d_*). Data wins conflicts,
// but after STARVE_LIMIT consecutive data grants with a fetch waiting, the
// fetch is granted.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_addr             fetch request and word address
//   i_ready                  fetch accepted this cycle (combinational)
//   i_rvalid/i_rdata         fetch response, one cycle after i_ready
//   d_req/d_addr/d_wdata     data request, address, store data
//   d_wstrb                  byte enables, 0 = read
//   d_ready                  data request accepted this cycle (combinational)
//   d_rvalid/d_rdata         load response, one cycle after d_ready (reads only)
//   ram_en/ram_we/ram_addr/ram_wdata  RAM macro command
//   ram_rdata                RAM read data, valid the cycle after a read
module ram_port_arbiter
  import soc_mem_pkg::*;
#(
  parameter int RAM_AW       = RAM_AW_DEFAULT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [RAM_AW-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [RAM_AW-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  logic [STREAK_W-1:0] streak_q, streak_d;
  owner_e              owner_q, owner_d;
  logic [31:0]         i_hold, d_hold;
  logic                grant_i, grant_d;

  // Grant decision and RAM command mux. No grants are made while in reset.
  // The streak saturates at LIMIT, so ">=" is the same as "==" but robust.
  always_comb begin
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    streak_d  = streak_q;
    owner_d   = OWNER_NONE;

    if (!rst) begin
      if (d_req && i_req) begin
        if (streak_q >= LIMIT) grant_i = 1'b1;
        else                   grant_d = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end

    if (grant_d) begin
      ram_en    = 1'b1;
      ram_we    = d_wstrb;
      ram_addr  = d_addr;
      ram_wdata = d_wdata;
      owner_d   = (d_wstrb == 4'b0000) ? OWNER_D_RD : OWNER_NONE;
    end else if (grant_i) begin
      ram_en   = 1'b1;
      ram_addr = i_addr;
      owner_d  = OWNER_I;
    end

    // The streak only counts data grants that made a pending fetch wait.
    if (!i_req || grant_i) begin
      streak_d = '0;
    end else if (grant_d && (streak_q < LIMIT)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  assign i_ready = grant_i;
  assign d_ready = grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
      owner_q  <= OWNER_NONE;
    end else begin
      streak_q <= streak_d;
      owner_q  <= owner_d;
    end
  end

  // A response still in flight when reset arrives is dropped, so rvalid is
  // also masked by rst for the cycle in which reset is applied.
  assign i_rvalid = !rst && (owner_q == OWNER_I);
  assign d_rvalid = !rst && (owner_q == OWNER_D_RD);

  // Hold registers keep the last response visible between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_hold <= 32'h0;
      d_hold <= 32'h0;
    end else begin
      if (i_rvalid) i_hold <= ram_rdata;
      if (d_rvalid) d_hold <= ram_rdata;
    end
  end

  assign i_rdata = rst ? 32'h0 : (i_rvalid ? ram_rdata : i_hold);
  assign d_rdata = rst ? 32'h0 : (d_rvalid ? ram_rdata : d_hold);

`ifndef SYNTHESIS
  // Masters must hold a request until it is accepted.
  i_req_held : assert property (@(posedge clk) disable iff (rst)
                                (i_req && !i_ready) |=> i_req);
  d_req_held : assert property (@(posedge clk) disable iff (rst)
                                (d_req && !d_ready) |=> d_req);
`endif

endmodule
